// File: rtl/pp_resolve_pipe_if.sv
// Handshake and data bundle for pp_resolve_pipe.
// master: upstream/downstream environment side, slave: the resolver itself.
interface pp_resolve_pipe_if #(
   parameter int unsigned width = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [width-1:0] s_u_m;
   logic [width-1:0] c_arr_y;
   logic             out_valid;
   logic             out_ready;
   logic [width-1:0] result;
   logic             ovf;
   logic [1:0]       occupancy;

   modport master (
      output in_valid, s_u_m, c_arr_y, out_ready,
      input  in_ready, out_valid, result, ovf, occupancy
   );

   modport slave (
      input  in_valid, s_u_m, c_arr_y, out_ready,
      output in_ready, out_valid, result, ovf, occupancy
   );
endinterface

// File: rtl/pp_resolve_pipe.sv
// Two-stage carry-save resolver: result = (s_u_m + (c_arr_y << 1)) mod 2^width.
// Stage 1 adds the low halves, stage 2 adds the upper halves plus the low carry.
// Optional macro PP_RESOLVE_OVF_EN enables the ovf flag (upper carry-out OR
// c_arr_y[width-1]); when undefined, ovf is tied to 0.
// width must be even and at least 4.
module pp_resolve_pipe #(
   parameter int unsigned width = 32
) (
   input logic              clk,
   input logic              rst_n,
   pp_resolve_pipe_if.slave bus
);

   localparam int unsigned half = width / 2;

   logic             s1_valid;
   logic             s2_valid;
   logic [half-1:0]  s1_lo;
   logic             s1_cout;
   logic [half-1:0]  s1_s_hi;
   logic [half-1:0]  s1_c_hi;
   logic [width-1:0] result_q;
   logic [1:0]       occ_q;

   logic [half:0]    lo_sum;
   logic             s2_load;
   logic             s1_adv;
   logic             in_rdy;
   logic             in_fire;
   logic             out_fire;

`ifdef PP_RESOLVE_OVF_EN
   logic             s1_c_top;
   logic             ovf_q;
   logic [half:0]    hi_sum;
`else
   logic [half-1:0]  hi_sum;
`endif

   // Handshake: stage 2 loads when empty or draining; stage 1 follows it.
   always_comb begin
      s2_load  = !s2_valid || bus.out_ready;
      s1_adv   = s1_valid && s2_load;
      in_rdy   = !s1_valid || s1_adv;
      in_fire  = bus.in_valid && in_rdy;
      out_fire = s2_valid && bus.out_ready;
   end

   // Low-half add; the shifted carry row contributes a 0 at bit 0.
   always_comb begin
      lo_sum = {1'b0, bus.s_u_m[half-1:0]} + {1'b0, bus.c_arr_y[half-2:0], 1'b0};
   end

   // Upper-half add from the registered halves plus the stage-1 carry.
   always_comb begin
`ifdef PP_RESOLVE_OVF_EN
      hi_sum = {1'b0, s1_s_hi} + {1'b0, s1_c_hi} + {{half{1'b0}}, s1_cout};
`else
      hi_sum = s1_s_hi + s1_c_hi + {{(half-1){1'b0}}, s1_cout};
`endif
   end

   // Stage valid flags and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         occ_q    <= '0;
      end else begin
         if (in_fire)
            s1_valid <= 1'b1;
         else if (s1_adv)
            s1_valid <= 1'b0;
         if (s2_load)
            s2_valid <= s1_valid;
         case ({in_fire, out_fire})
            2'b10:   occ_q <= occ_q + 2'd1;
            2'b01:   occ_q <= occ_q - 2'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Stage-1 datapath capture; upper carry half is the row shifted by one.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_lo   <= lo_sum[half-1:0];
         s1_cout <= lo_sum[half];
         s1_s_hi <= bus.s_u_m[width-1:half];
         s1_c_hi <= bus.c_arr_y[width-2:half-1];
      end
   end

   // Output register; holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         result_q <= '0;
      else if (s1_adv)
         result_q <= {hi_sum[half-1:0], s1_lo};
   end

`ifdef PP_RESOLVE_OVF_EN
   // Carry row MSB is lost by the shift; carry it along with stage 1.
   always_ff @(posedge clk) begin
      if (in_fire)
         s1_c_top <= bus.c_arr_y[width-1];
   end

   // Overflow flag travels with its result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else if (s1_adv)
         ovf_q <= hi_sum[half] | s1_c_top;
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = s2_valid;
   assign bus.result    = result_q;
   assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_pp_resolve_pipe.sv
// Scoreboard bench for pp_resolve_pipe: accepted pairs push a reference
// result; each output transfer pops and compares.
module tb_pp_resolve_pipe;

   localparam int unsigned W = 32;
`ifdef PP_RESOLVE_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] res;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   exp_t         sb[$];
   int           occ_m = 0;
   logic         hold = 1'b0;
   logic [W-1:0] hold_res;
   logic         hold_ovf;
   logic         rnd_done;

   pp_resolve_pipe_if #(.width(W)) bus ();

   pp_resolve_pipe #(.width(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] c);
      logic [W:0] t;
      exp_t       e;
      t     = {1'b0, s} + {1'b0, c[W-2:0], 1'b0};
      e.res = t[W-1:0];
      e.ovf = OVF_ON & (t[W] | c[W-1]);
      return e;
   endfunction

   // Monitor: occupancy model, stall stability and scoreboard compare.
   always @(negedge clk) begin
      exp_t e;
      logic in_f, out_f;
      if (!rst_n) begin
         sb.delete();
         occ_m = 0;
         hold  = 1'b0;
      end else begin
         check("occupancy", 64'(bus.occupancy), 64'(occ_m));
         if (hold) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_result", 64'(bus.result), 64'(hold_res));
            check("hold_ovf", 64'(bus.ovf), 64'(hold_ovf));
         end
         out_f = bus.out_valid && bus.out_ready;
         in_f  = bus.in_valid && bus.in_ready;
         if (out_f) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("result", 64'(bus.result), 64'(e.res));
               check("ovf", 64'(bus.ovf), 64'(e.ovf));
            end
         end
         hold     = bus.out_valid && !bus.out_ready;
         hold_res = bus.result;
         hold_ovf = bus.ovf;
         if (in_f)
            sb.push_back(model(bus.s_u_m, bus.c_arr_y));
         occ_m = occ_m + int'(in_f) - int'(out_f);
      end
   end

   // Present a pair and hold it until accepted; returns stall cycles.
   task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, output int waits);
      waits        = 0;
      bus.in_valid = 1'b1;
      bus.s_u_m    = s;
      bus.c_arr_y  = c;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         waits++;
         if (waits >= 50) begin
            check("send_timeout", 64'(waits), 64'd0);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 64'(n >= 100), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [W-1:0] r0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.s_u_m     = '0;
      bus.c_arr_y   = '0;
      rnd_done      = 1'b0;

      // Reset state
      #12;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_occ", 64'(bus.occupancy), 64'd0);
      check("rst_result", 64'(bus.result), 64'd0);
      check("rst_ovf", 64'(bus.ovf), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Cross-half carry and exact latency
      bus.out_ready = 1'b1;
      send(32'h0000_FFFF, 32'h0000_0001, w);
      check("lat_early", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      check("lat_valid", 64'(bus.out_valid), 64'd1);
      check("cross_half", 64'(bus.result), 64'h0001_0001);
      check("cross_ovf", 64'(bus.ovf), 64'd0);
      drain();

      // Streaming k,k -> 3k, no stalls, pipe stays full
      for (int k = 0; k < 8; k++) begin
         send(W'(k), W'(k), w);
         check("stream_stall", 64'(w), 64'd0);
         if (k >= 1) check("stream_occ", 64'(bus.occupancy), 64'd2);
      end
      drain();

      // Back-pressure: two accepted, third blocked, output held
      bus.out_ready = 1'b0;
      send(32'd10, 32'd3, w);
      send(32'd20, 32'd4, w);
      bus.in_valid = 1'b1;
      bus.s_u_m    = 32'd30;
      bus.c_arr_y  = 32'd5;
      r0 = bus.result;
      check("bp_first", 64'(r0), 64'd16);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
         check("bp_occ", 64'(bus.occupancy), 64'd2);
         check("bp_stable", 64'(bus.result), 64'(r0));
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      send(32'd30, 32'd5, w);
      drain();

      // Overflow wrap
      send(32'hFFFF_FFFF, 32'h0000_0001, w);
      @(posedge clk); #1;
      check("wrap_result", 64'(bus.result), 64'd1);
      check("wrap_ovf", 64'(bus.ovf), 64'(OVF_ON));
      drain();

      // Top carry bit shifted out
      send(32'h0000_0000, 32'h8000_0000, w);
      @(posedge clk); #1;
      check("top_result", 64'(bus.result), 64'd0);
      check("top_ovf", 64'(bus.ovf), 64'(OVF_ON));
      drain();

      // Random traffic with random back-pressure
      fork
         begin
            for (int i = 0; i < 40; i++)
               send(W'($urandom()), W'($urandom()), w);
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.out_ready = 1'b1;
      drain();

      // Reset mid-flight with a full pipe
      bus.out_ready = 1'b0;
      send(32'd5, 32'd5, w);
      send(32'd6, 32'd6, w);
      check("mid_occ_full", 64'(bus.occupancy), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_out_valid", 64'(bus.out_valid), 64'd0);
      check("mid_occ", 64'(bus.occupancy), 64'd0);
      check("mid_result", 64'(bus.result), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      check("mid_in_ready", 64'(bus.in_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("mid_no_stale", 64'(bus.out_valid), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pp_resolve_pipe.md
PP_RESOLVE_PIPE -- requirements
Module: pp_resolve_pipe

Interface
REQ-001 Parameter: width, default 32, operand and result width in bits; SHALL be even and at least 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream holds a valid redundant pair.
REQ-005 in_ready  output  1  block accepts the pair this cycle.
REQ-006 s_u_m  input  width  redundant sum row, same weight.
REQ-007 c_arr_y  input  width  redundant carry row, unshifted; the block applies the <<1.
REQ-008 out_valid  output  1  result is valid.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 result  output  width  resolved value, (s_u_m + (c_arr_y<<1)) mod 2^width.
REQ-011 ovf  output  1  bits lost above width; see Configuration.
REQ-012 occupancy  output  2  number of pairs held in the pipe, 0..2.

Function
REQ-013 A transfer in SHALL occur when in_valid and in_ready are both 1; a transfer out SHALL occur when out_valid and out_ready are both 1.
REQ-014 Stage 1 SHALL compute the low half: s_u_m[width/2-1:0] plus {c_arr_y[width/2-2:0],1'b0}. It SHALL register the low-half result, the low-half carry-out, and the upper halves of both rows.
REQ-015 Stage 2 SHALL compute the upper half: the registered upper sum half, plus the upper shifted-carry half, plus the stage-1 carry. It SHALL register the full result in the output register.
REQ-016 Latency SHALL be exactly 2 cycles from an accepted input to out_valid, with no stalls.
REQ-017 With out_ready held at 1, throughput SHALL be one result per cycle.
REQ-018 Stage 2 SHALL load when it is empty or drained in the same cycle.
REQ-019 Stage 1 SHALL advance into stage 2 whenever stage 2 loads.
REQ-020 in_ready SHALL equal (stage 1 empty) OR (stage 1 advancing this cycle). This is a combinational path from out_ready only, never from in_valid.
REQ-021 result and ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 occupancy SHALL increment on an in-only transfer and decrement on an out-only transfer. It SHALL be unchanged on simultaneous in and out transfers or when idle.
REQ-023 When full (occupancy=2) and out_ready=0, in_ready SHALL be 0 and no data SHALL be overwritten.
REQ-024 When full, a simultaneous out and in transfer SHALL keep occupancy at 2 with no bubble.
REQ-025 Wrap-around: a sum exceeding 2^width-1 SHALL be truncated modulo 2^width.

Reset
REQ-026 While rst_n=0, the following SHALL be 0 immediately, independent of clk: out_valid, occupancy, ovf, result, and both stage-valid flags.
REQ-027 After reset, in_ready SHALL be 1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight pairs; no result SHALL emerge after deassertion.
REQ-029 Datapath registers other than result need not be reset.

Configuration
REQ-030 Macro PP_RESOLVE_OVF_EN, when defined, SHALL make ovf equal the OR of the upper-half carry-out and c_arr_y[width-1]. ovf SHALL be pipelined alongside its result.
REQ-031 Without PP_RESOLVE_OVF_EN, ovf SHALL be tied to 0 and no overflow logic SHALL be synthesized. All other behaviour SHALL be identical.

Verification
REQ-032 Cross-half carry: width=32, s_u_m=32'h0000_FFFF, c_arr_y=32'h0000_0001, out_ready=1 -> after 2 cycles result=32'h0001_0001, ovf=0.
REQ-033 Streaming: 8 back-to-back pairs (k, k) for k=0..7, out_ready=1 -> results 3k on consecutive cycles, occupancy stays at 2 once the pipe fills.
REQ-034 Back-pressure: out_ready=0, offer 3 pairs -> 2 accepted, in_ready=0, occupancy=2, result stable. Raise out_ready -> all 3 results in order.
REQ-035 Overflow: s_u_m=32'hFFFF_FFFF, c_arr_y=32'h0000_0001 -> result=32'h0000_0001. ovf=1 with the macro, ovf=0 without.
REQ-036 Top-bit drop: c_arr_y=32'h8000_0000, s_u_m=0 -> result=0. ovf=1 with the macro.
REQ-037 Reset mid-flight: assert rst_n=0 with occupancy=2 -> out_valid=0 and occupancy=0 immediately, in_ready=1 after release, no stale result emerges.
